// File: rtl/fmadd_exp_align_pipe_pkg.sv
// fmadd_exp_align_pipe_pkg: shared FPU constants for opcode decoding and GRS bit positions
package fmadd_exp_align_pipe_pkg;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int GUARD_OFS = 1;
  localparam int ROUND_OFS = 2;
  localparam int STICKY_OFS = 3;
  function automatic logic op_invalid(input logic [1:0] op);
    return op[OP_ADD] == op[OP_SUB];
  endfunction
endpackage

// File: rtl/fmadd_align_shifter.sv
// fmadd_align_shifter: right-align the smaller-exponent mantissa and extract guard/round/sticky
module fmadd_align_shifter
  import fmadd_exp_align_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 48
) (
  input  logic [MAN_W-1:0] operand,
  input  logic [EXP_W-1:0] diff,
  output logic [MAN_W-1:0] aligned,
  output logic             guard,
  output logic             round,
  output logic             sticky
);
  logic [2*MAN_W-1:0] full;
  logic [2*MAN_W-1:0] wide;
  assign full = {operand, {MAN_W{1'b0}}};
  assign wide = full >> diff;
  assign aligned = wide[2*MAN_W-1:MAN_W];
  assign guard = wide[MAN_W-GUARD_OFS];
  assign round = wide[MAN_W-ROUND_OFS];
  // Shifting back and comparing catches every bit that fell off the bottom, including diff >= 2*MAN_W.
  assign sticky = (|wide[MAN_W-STICKY_OFS:0]) | ((wide << diff) != full);
endmodule

// File: rtl/fmadd_exp_align_pipe.sv
// fmadd_exp_align_pipe: two-stage FMA exponent compare/swap and mantissa alignment pipeline
module fmadd_exp_align_pipe
  import fmadd_exp_align_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 48,
  parameter int DIFF_LIMIT = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign_a,
  input  logic             in_sign_b,
  input  logic [EXP_W-1:0] in_exp_a,
  input  logic [EXP_W-1:0] in_exp_b,
  input  logic [MAN_W-1:0] in_man_a,
  input  logic [MAN_W-1:0] in_man_b,
  input  logic [1:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_man_a,
  output logic [MAN_W-1:0] out_man_b,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_eff_add,
  output logic             out_eff_sub,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_diff_check,
  output logic             out_op_err
);
  logic s1_valid, s2_valid, s1_ready, s2_ready;
  logic a_ge, sgn_x, op_err, eff_add, eff_sub, sign;
  logic [EXP_W-1:0] diff;
  logic s1_a_ge, s1_sign, s1_eff_add, s1_eff_sub, s1_op_err, s1_diff_check;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [MAN_W-1:0] s1_man_big, s1_man_small, aligned;
  logic guard, round, sticky;
  assign s2_ready = ~s2_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = s1_ready;
  assign out_valid = s2_valid;
  assign a_ge = in_exp_a >= in_exp_b;
  assign diff = a_ge ? in_exp_a - in_exp_b : in_exp_b - in_exp_a;
  assign sgn_x = in_sign_a ^ in_sign_b;
  assign op_err = op_invalid(in_opcode);
  assign eff_add = ~op_err & (sgn_x ? in_opcode[OP_SUB] : in_opcode[OP_ADD]);
  assign eff_sub = ~op_err & (sgn_x ? in_opcode[OP_ADD] : in_opcode[OP_SUB]);
  assign sign = (eff_add | (in_exp_a > in_exp_b & eff_sub) |
                 (in_exp_a == in_exp_b & eff_sub & in_man_a >= in_man_b))
              ? in_sign_a : in_sign_b ^ in_opcode[OP_SUB];
  // Stage occupancy; reset wins so nothing presented during reset is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (s2_ready) s2_valid <= s1_valid;
    end
  end
  // S1 payload: compare/swap result; the tie case keeps A as the big operand so B is shifted.
  always_ff @(posedge clk) begin
    if (in_valid && s1_ready) begin
      s1_a_ge       <= a_ge;
      s1_exp        <= a_ge ? in_exp_a : in_exp_b;
      s1_diff       <= diff;
      s1_man_big    <= a_ge ? in_man_a : in_man_b;
      s1_man_small  <= a_ge ? in_man_b : in_man_a;
      s1_sign       <= sign;
      s1_eff_add    <= eff_add;
      s1_eff_sub    <= eff_sub;
      s1_op_err     <= op_err;
      s1_diff_check <= 32'(diff) >= 32'(DIFF_LIMIT);
    end
  end
  fmadd_align_shifter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_shift (
    .operand(s1_man_small),
    .diff   (s1_diff),
    .aligned(aligned),
    .guard  (guard),
    .round  (round),
    .sticky (sticky)
  );
  // S2 payload: aligned mantissas placed back in A/B order; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (s1_valid && s2_ready) begin
      out_man_a      <= s1_a_ge ? s1_man_big : aligned;
      out_man_b      <= s1_a_ge ? aligned : s1_man_big;
      out_exp        <= s1_exp;
      out_sign       <= s1_sign;
      out_eff_add    <= s1_eff_add;
      out_eff_sub    <= s1_eff_sub;
      out_guard      <= guard;
      out_round      <= round;
      out_sticky     <= sticky;
      out_diff_check <= s1_diff_check;
      out_op_err     <= s1_op_err;
    end
  end
endmodule

// File: tb/tb_fmadd_exp_align_pipe.sv
// tb_fmadd_exp_align_pipe: directed and randomized checks against a bit-placement reference model
module tb_fmadd_exp_align_pipe;
  typedef struct packed {
    logic sa, sb;
    logic [7:0] ea, eb;
    logic [47:0] ma, mb;
    logic [1:0] op;
  } txn_t;
  typedef struct packed {
    logic [47:0] man_a, man_b;
    logic [7:0] exp;
    logic sign, eadd, esub, g, r, s, dc, err;
  } res_t;

  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sign_a = 0, in_sign_b = 0;
  logic [7:0] in_exp_a = 0, in_exp_b = 0;
  logic [47:0] in_man_a = 0, in_man_b = 0;
  logic [1:0] in_opcode = 0;
  logic out_valid, out_ready = 0;
  logic [47:0] out_man_a, out_man_b;
  logic [7:0] out_exp;
  logic out_sign, out_eff_add, out_eff_sub, out_guard, out_round, out_sticky, out_diff_check, out_op_err;
  int checks = 0, errors = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  fmadd_exp_align_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign_a(in_sign_a), .in_sign_b(in_sign_b), .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .in_man_a(in_man_a), .in_man_b(in_man_b), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_man_a(out_man_a), .out_man_b(out_man_b),
    .out_exp(out_exp), .out_sign(out_sign), .out_eff_add(out_eff_add), .out_eff_sub(out_eff_sub),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_diff_check(out_diff_check), .out_op_err(out_op_err)
  );

  // Reference: walk each operand bit to where it lands after shifting by the exponent gap.
  function automatic res_t model(input txn_t t);
    res_t e;
    logic age;
    int diff;
    logic [47:0] opnd;
    logic x;
    e = '0;
    age = t.ea >= t.eb;
    diff = age ? int'(t.ea) - int'(t.eb) : int'(t.eb) - int'(t.ea);
    opnd = age ? t.mb : t.ma;
    for (int i = 0; i < 48; i++)
      if (opnd[i]) begin
        if (i >= diff) e.man_b[i-diff] = 1'b1;
        else if (i == diff - 1) e.g = 1'b1;
        else if (i == diff - 2) e.r = 1'b1;
        else e.s = 1'b1;
      end
    e.man_a = age ? t.ma : e.man_b;
    e.man_b = age ? e.man_b : t.mb;
    e.exp = age ? t.ea : t.eb;
    e.dc = diff >= 48;
    x = t.sa ^ t.sb;
    e.err = (t.op == 2'b00) || (t.op == 2'b11);
    e.eadd = e.err ? 1'b0 : (x ? t.op[1] : t.op[0]);
    e.esub = e.err ? 1'b0 : (x ? t.op[0] : t.op[1]);
    if (e.eadd || (t.ea > t.eb && e.esub) || (t.ea == t.eb && e.esub && t.ma >= t.mb)) e.sign = t.sa;
    else e.sign = t.sb ^ t.op[1];
    return e;
  endfunction

  function automatic res_t dut_out();
    return '{out_man_a, out_man_b, out_exp, out_sign, out_eff_add, out_eff_sub,
             out_guard, out_round, out_sticky, out_diff_check, out_op_err};
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.sa = 1'($urandom); t.sb = 1'($urandom);
    t.ea = 8'($urandom);
    case ($urandom_range(0, 3))
      0: t.eb = t.ea;
      1: t.eb = t.ea - 8'($urandom_range(0, 60));
      2: t.eb = t.ea + 8'($urandom_range(0, 110));
      default: t.eb = 8'($urandom);
    endcase
    t.ma = ($urandom_range(0, 7) == 0) ? 48'd0 : 48'({$urandom(), $urandom()});
    t.mb = ($urandom_range(0, 7) == 0) ? 48'd0 : 48'({$urandom(), $urandom()});
    t.op = 2'($urandom_range(0, 3));
    return t;
  endfunction

  task automatic drive(input txn_t t, input logic v);
    in_valid = v; in_sign_a = t.sa; in_sign_b = t.sb; in_exp_a = t.ea; in_exp_b = t.eb;
    in_man_a = t.ma; in_man_b = t.mb; in_opcode = t.op;
  endtask

  // Push one transaction through an empty pipe; seen reports out_valid exactly two edges after acceptance.
  task automatic run_one(input txn_t t, output res_t got, output logic seen);
    @(negedge clk);
    drive(t, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    seen = out_valid;
    got = dut_out();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_small_shift();
    txn_t t; res_t got; logic seen;
    t = '{1'b0, 1'b0, 8'h85, 8'h82, 48'h123456789abc, 48'h800000000001, 2'b01};
    run_one(t, got, seen);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL small_shift_latency out_valid=%b want 1", seen); end
    checks++;
    if ({got.man_b, got.exp, got.g, got.r, got.s, got.eadd, got.sign} !== {48'h100000000000, 8'h85, 5'b00110}) begin
      errors++;
      $display("FAIL small_shift man_b=%h exp=%h grs=%b%b%b add=%b sign=%b want 100000000000 85 001 1 0",
               got.man_b, got.exp, got.g, got.r, got.s, got.eadd, got.sign);
    end
    checks++;
    if (got !== model(t)) begin errors++; $display("FAIL small_shift_model got=%h want=%h", got, model(t)); end
  endtask

  task automatic test_tie_sub();
    txn_t t; res_t got; logic seen;
    t = '{1'b0, 1'b0, 8'h80, 8'h80, 48'h400000000000, 48'h800000000000, 2'b10};
    run_one(t, got, seen);
    checks++;
    if (seen !== 1'b1 || {got.esub, got.eadd, got.sign, got.man_a, got.man_b, got.g, got.r, got.s} !==
        {3'b101, 48'h400000000000, 48'h800000000000, 3'b000}) begin
      errors++;
      $display("FAIL tie_sub valid=%b sub=%b add=%b sign=%b a=%h b=%h grs=%b%b%b", seen, got.esub, got.eadd,
               got.sign, got.man_a, got.man_b, got.g, got.r, got.s);
    end
  endtask

  task automatic test_huge_diff();
    txn_t t; res_t got; logic seen;
    t = '{1'b1, 1'b0, 8'hE4, 8'h80, 48'hfedcba987654, 48'h000000000001, 2'b01};
    run_one(t, got, seen);
    checks++;
    if (seen !== 1'b1 || {got.man_b, got.g, got.r, got.s, got.dc} !== {48'd0, 4'b0011}) begin
      errors++;
      $display("FAIL huge_diff_one valid=%b b=%h grs=%b%b%b dc=%b want 0 001 1", seen, got.man_b, got.g, got.r, got.s, got.dc);
    end
    t.mb = 48'd0;
    run_one(t, got, seen);
    checks++;
    if (seen !== 1'b1 || {got.man_b, got.g, got.r, got.s, got.dc} !== {48'd0, 4'b0001}) begin
      errors++;
      $display("FAIL huge_diff_zero valid=%b b=%h grs=%b%b%b dc=%b want 0 000 1", seen, got.man_b, got.g, got.r, got.s, got.dc);
    end
    checks++;
    if (got !== model(t)) begin errors++; $display("FAIL huge_diff_model got=%h want=%h", got, model(t)); end
  endtask

  task automatic test_back_to_back();
    txn_t t[4];
    int sent = 0, recv = 0;
    for (int i = 0; i < 4; i++) t[i] = rand_txn();
    sb.delete();
    for (int c = 0; c < 40 && recv < 4; c++) begin
      @(negedge clk);
      if (sent < 4) drive(t[sent], 1'b1); else in_valid = 1'b0;
      out_ready = c >= 4;
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_out() !== model(t[0])) begin
          errors++;
          $display("FAIL b2b_stall c=%0d in_ready=%b out_valid=%b got=%h want=%h", c, in_ready, out_valid, dut_out(), model(t[0]));
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0 || dut_out() !== sb[0]) begin
          errors++;
          $display("FAIL b2b_order got=%h queued=%0d", dut_out(), sb.size());
        end
        if (sb.size() != 0) void'(sb.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin sb.push_back(model(t[sent])); sent++; end
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 4) begin errors++; $display("FAIL b2b_count got=%0d want 4", recv); end
  endtask

  task automatic test_random();
    txn_t t;
    int recv = 0;
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      t = rand_txn();
      drive(t, $urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 9) < 7;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0 || dut_out() !== sb[0]) begin
          errors++;
          $display("FAIL random_out got=%h want=%h queued=%0d", dut_out(), sb.size() ? sb[0] : '0, sb.size());
        end
        if (sb.size() != 0) void'(sb.pop_front());
        recv++;
      end
      if (in_valid && in_ready) sb.push_back(model(t));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        checks++;
        if (dut_out() !== sb[0]) begin errors++; $display("FAIL random_drain got=%h want=%h", dut_out(), sb[0]); end
        void'(sb.pop_front());
      end
    end
    checks++;
    if (sb.size() != 0 || recv == 0) begin errors++; $display("FAIL random_lost left=%0d recv=%0d", sb.size(), recv); end
  endtask

  task automatic test_reset_midstream();
    txn_t t; res_t got; logic seen;
    int stray = 0;
    @(negedge clk); drive(rand_txn(), 1'b1); out_ready = 1'b0;
    @(negedge clk); drive(rand_txn(), 1'b1);
    @(negedge clk); drive(rand_txn(), 1'b1); rst = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); #1; if (out_valid) stray++; end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL mid_reset_stray got=%0d want 0", stray); end
    t = rand_txn();
    t.op = 2'b11;
    run_one(t, got, seen);
    checks++;
    if (seen !== 1'b1 || {got.err, got.eadd, got.esub} !== 3'b100 || got !== model(t)) begin
      errors++;
      $display("FAIL op_err valid=%b got=%h want=%h", seen, got, model(t));
    end
  endtask

  initial begin
    test_reset();
    test_small_shift();
    test_tie_sub();
    test_huge_diff();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
